// File: rtl/present_serial_ctrl.sv
// ---------------------------------------------------------------------------
// present_serial_ctrl
//
// Serialised PRESENT-80 encryption engine. A single 4-bit PRESENT sbox is
// time-shared between the 16 state nibbles (one per cycle in SBOX) and the
// top nibble of the key schedule (in PLAY). Each round is
// ARK (1) + SBOX (16) + PLAY (1) = 18 cycles. After ROUNDS rounds, FINAL
// applies the last round key and DONE holds the ciphertext.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   plaintext/key offered by the producer
//   in_ready   engine can accept a block (IDLE only)
//   pt[63:0]   plaintext, bit 63 = MSB
//   key[79:0]  cipher key, bit 79 = MSB
//   out_valid  ciphertext valid, held until out_ready
//   out_ready  consumer accepts the ciphertext
//   ct[63:0]   ciphertext, holds until the next FINAL
//   busy       high in ARK/SBOX/PLAY/FINAL
//   round[4:0] current round, 1..ROUNDS while running, 0 in IDLE
//   abort      only with PRESENT_ABORT_EN: drops an operation in progress
//
// Build option:
//   PRESENT_ABORT_EN  adds the abort input. Without it an operation always
//                     runs to DONE and only rst can stop it.
// ---------------------------------------------------------------------------

// PRESENT 4-bit substitution box.
module present_sbox (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = 4'h0;
        case (din)
            4'h0: dout = 4'hC;
            4'h1: dout = 4'h5;
            4'h2: dout = 4'h6;
            4'h3: dout = 4'hB;
            4'h4: dout = 4'h9;
            4'h5: dout = 4'h0;
            4'h6: dout = 4'hA;
            4'h7: dout = 4'hD;
            4'h8: dout = 4'h3;
            4'h9: dout = 4'hE;
            4'hA: dout = 4'hF;
            4'hB: dout = 4'h8;
            4'hC: dout = 4'h4;
            4'hD: dout = 4'h7;
            4'hE: dout = 4'h1;
            4'hF: dout = 4'h2;
            default: dout = 4'h0;
        endcase
    end
endmodule

module present_serial_ctrl #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] pt,
    input  logic [79:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ct,
    output logic        busy,
    output logic [4:0]  round
`ifdef PRESENT_ABORT_EN
    ,
    input  logic        abort
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARK   = 3'd1,
        SBOX  = 3'd2,
        PLAY  = 3'd3,
        FINAL = 3'd4,
        DONE  = 3'd5
    } state_t;

    // The counter reaches ROUNDS+1 at FINAL/DONE, which does not fit the
    // 5-bit port for ROUNDS=31, so it is kept one bit wider internally.
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS);

    state_t      state, state_nx;
    logic [63:0] st;        // cipher state
    logic [79:0] kr;        // key register
    logic [3:0]  nib;       // nibble index during SBOX
    logic [5:0]  rnd;       // round counter
    logic [63:0] ct_q;

    logic [3:0]  sbox_in, sbox_out;
    logic [79:0] key_rot, key_nx;
    logic [63:0] play;
    logic        abort_hit;

    // ---------------------------------------------------------------
    // Abort qualification: only meaningful while an operation runs.
    // ---------------------------------------------------------------
`ifdef PRESENT_ABORT_EN
    assign abort_hit = abort && (state == ARK || state == SBOX ||
                                 state == PLAY || state == FINAL);
`else
    assign abort_hit = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Shared sbox. The state nibble owns it in SBOX, the rotated key's
    // top nibble in PLAY; otherwise its input is tied low.
    // ---------------------------------------------------------------
    assign key_rot = {kr[18:0], kr[79:19]};   // rotate left by 61

    always_comb begin
        sbox_in = 4'h0;
        if (state == SBOX)
            sbox_in = st[{nib, 2'b00} +: 4];
        else if (state == PLAY)
            sbox_in = key_rot[79:76];
    end

    present_sbox u_sbox (
        .din  (sbox_in),
        .dout (sbox_out)
    );

    // Next round key: sbox on the top nibble, round counter into [19:15].
    assign key_nx = {sbox_out, key_rot[75:20], key_rot[19:15] ^ rnd[4:0], key_rot[14:0]};

    // ---------------------------------------------------------------
    // pLayer: bit i -> bit (16*i mod 63), bit 63 fixed. Pure wiring.
    // ---------------------------------------------------------------
    for (genvar i = 0; i < 63; i++) begin : g_play
        assign play[(16 * i) % 63] = st[i];
    end
    assign play[63] = st[63];

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // ---------------------------------------------------------------
    // FSM: next state and handshake/status outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = ARK;
            end
            ARK: begin
                busy     = 1'b1;
                state_nx = SBOX;
            end
            SBOX: begin
                busy = 1'b1;
                if (nib == 4'hF)
                    state_nx = PLAY;
            end
            PLAY: begin
                busy     = 1'b1;
                state_nx = (rnd == LAST_ROUND) ? FINAL : ARK;
            end
            FINAL: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort_hit)
            state_nx = IDLE;
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= '0;
            kr   <= '0;
            nib  <= '0;
            rnd  <= '0;
            ct_q <= '0;
        end else if (abort_hit) begin
            // Drop the operation; ct keeps the previous result.
            rnd <= '0;
            nib <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st  <= pt;
                        kr  <= key;
                        rnd <= 6'd1;
                        nib <= '0;
                    end
                end
                ARK: begin
                    st  <= st ^ kr[79:16];
                    nib <= '0;
                end
                SBOX: begin
                    st[{nib, 2'b00} +: 4] <= sbox_out;
                    nib <= nib + 4'd1;
                end
                PLAY: begin
                    st  <= play;
                    kr  <= key_nx;
                    rnd <= rnd + 6'd1;
                end
                FINAL: begin
                    ct_q <= st ^ kr[79:16];
                end
                DONE: begin
                    if (out_ready)
                        rnd <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ct    = ct_q;
    assign round = rnd[4:0];

endmodule

// File: tb/tb_present_serial_ctrl.sv
// Bench for present_serial_ctrl (ROUNDS=31). Known-answer vectors are the
// published PRESENT-80 test vectors.
module tb_present_serial_ctrl;

    localparam int ROUNDS = 31;
    localparam int LAT    = 18 * ROUNDS + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pt_i;
    logic [79:0] key_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ct;
    logic        busy;
    logic [4:0]  round;
`ifdef PRESENT_ABORT_EN
    logic        abort;
`endif

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    present_serial_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt        (pt_i),
        .key       (key_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct),
        .busy      (busy),
        .round     (round)
`ifdef PRESENT_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    typedef struct {
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] ct;
        int          hold;   // cycles to stall out_ready in DONE
        bit          noisy;  // keep in_valid high with junk after accept
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Offer a block, wait for DONE, stall for 'hold' cycles, then hand off.
    // Latency is counted in clock edges from the cycle the request is
    // presented (the accepting edge is edge 1).
    task automatic run_op(input logic [63:0] p, input logic [79:0] k,
                          input logic [63:0] exp, input int hold,
                          input bit noisy, input string tag);
        int lat;
        logic [63:0] held;
        pt_i      = p;
        key_i     = k;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        lat       = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                chk({tag, " busy_after_accept"}, 80'(busy), 80'(1));
                chk({tag, " in_ready_after_accept"}, 80'(in_ready), 80'(0));
                chk({tag, " round_first"}, 80'(round), 80'(1));
                if (noisy) begin
                    pt_i  = ~p;
                    key_i = ~k;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid || lat >= 1000) break;
        end
        in_valid = 1'b0;
        chk({tag, " done_reached"}, 80'(out_valid), 80'(1));
        if (!out_valid) return;
        chk({tag, " latency"}, 80'(lat), 80'(LAT));
        chk({tag, " ct"}, 80'(ct), 80'(exp));
        chk({tag, " busy_in_done"}, 80'(busy), 80'(0));
        held = ct;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            chk({tag, " stall_out_valid"}, 80'(out_valid), 80'(1));
            chk({tag, " stall_in_ready"}, 80'(in_ready), 80'(0));
            chk({tag, " stall_ct"}, 80'(ct), 80'(held));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " post_in_ready"}, 80'(in_ready), 80'(1));
        chk({tag, " post_out_valid"}, 80'(out_valid), 80'(0));
        chk({tag, " post_round"}, 80'(round), 80'(0));
        chk({tag, " post_ct_hold"}, 80'(ct), 80'(exp));
    endtask

    // Start an operation and return once 'round' reads r (bounded wait).
    task automatic start_and_wait_round(input logic [63:0] p, input logic [79:0] k,
                                        input logic [4:0] r, input string tag);
        int n;
        pt_i     = p;
        key_i    = k;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (round != r && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " reached_round"}, 80'(round), 80'(r));
    endtask

    initial begin
        vecs[0] = '{64'h0000000000000000, 80'h0,                     64'h5579C1387B228445, 0,  1'b0};
        vecs[1] = '{64'h0000000000000000, 80'hFFFFFFFFFFFFFFFFFFFF,  64'hE72C46C0F5945049, 0,  1'b1};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 80'h0,                     64'hA112FFC72F68417B, 2,  1'b0};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF,  64'h3333DCD3213210D2, 20, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt_i      = '0;
        key_i     = '0;
`ifdef PRESENT_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst in_ready",  80'(in_ready),  80'(1));
        chk("rst out_valid", 80'(out_valid), 80'(0));
        chk("rst busy",      80'(busy),      80'(0));
        chk("rst ct",        80'(ct),        80'(0));
        chk("rst round",     80'(round),     80'(0));

        // Known-answer vectors
        for (int v = 0; v < 4; v++)
            run_op(vecs[v].pt, vecs[v].key, vecs[v].ct, vecs[v].hold,
                   vecs[v].noisy, $sformatf("vec%0d", v));

        // Reset in the middle of SBOX of round 10
        start_and_wait_round(64'hFFFFFFFFFFFFFFFF, 80'h0123456789ABCDEF0123, 5'd10, "rstmid");
        repeat (3) @(posedge clk);   // ARK, then into SBOX
        #1;
        chk("rstmid busy_in_sbox", 80'(busy), 80'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstmid in_ready",  80'(in_ready),  80'(1));
        chk("rstmid out_valid", 80'(out_valid), 80'(0));
        chk("rstmid round",     80'(round),     80'(0));
        chk("rstmid busy",      80'(busy),      80'(0));
        chk("rstmid ct",        80'(ct),        80'(0));
        run_op(64'h0, 80'h0, 64'h5579C1387B228445, 0, 1'b0, "after_rst");

`ifdef PRESENT_ABORT_EN
        begin
            int seen;
            start_and_wait_round(64'h0, 80'hFFFFFFFFFFFFFFFFFFFF, 5'd5, "abort");
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            chk("abort in_ready", 80'(in_ready), 80'(1));
            chk("abort round",    80'(round),    80'(0));
            chk("abort busy",     80'(busy),     80'(0));
            seen = 0;
            for (int c = 0; c < LAT + 20; c++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("abort no_out_valid", 80'(seen), 80'(0));
            run_op(64'hFFFFFFFFFFFFFFFF, 80'h0, 64'hA112FFC72F68417B, 0, 1'b0, "after_abort");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
